// File: rtl/wc_pkg.sv
// Shared types and default sizes for the WC_4_4 tile sequencer.
package wc_pkg;

    localparam int DW_DEF       = 10;
    localparam int CALC_LAT_DEF = 3;
    localparam int NWGT         = 9;
    localparam int NDAT         = 16;
    localparam int NOUT         = 4;
    localparam int IDX_W        = 5;
    localparam int OIDX_W       = 2;
    localparam int TCNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_D,
        CALC,
        DRAIN
    } state_t;

endpackage

// File: rtl/wc_lat_timer.sv
// Loadable down-counter spanning the datapath compute latency.
module wc_lat_timer
    import wc_pkg::*;
#(
    parameter int LAT = CALC_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic first,
    output logic done
);

    localparam int CW = $clog2(LAT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter parks at 0, so first/done only fire once per load.
    assign first = (cnt_q == CW'(LAT));
    assign done  = (cnt_q == CW'(1));

endmodule

// File: rtl/wc_tile_seq.sv
// Beat sequencer between the D/Z pads and the WC_4_4 Winograd core.
module wc_tile_seq
    import wc_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int CALC_LAT = CALC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wload,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              dp_wr_en,
    output logic              dp_wr_sel,
    output logic [IDX_W-1:0]  dp_wr_idx,
    output logic [DW-1:0]     dp_wr_data,
    output logic              dp_start,
    output logic [OIDX_W-1:0] dp_out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [TCNT_W-1:0] tile_cnt
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OIDX_W-1:0]  oidx_q, oidx_d;
    logic [TCNT_W-1:0]  tile_q, tile_d;
    logic               pend_q, pend_d;
    logic               wgt_ok_q, wgt_ok_d;
    logic               wr_sel;
    logic               tmr_load;
    logic               tmr_first;
    logic               tmr_done;

    wc_lat_timer #(
        .LAT (CALC_LAT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .first (tmr_first),
        .done  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        oidx_d    = oidx_q;
        tile_d    = tile_q;
        pend_d    = pend_q | cfg_wload;
        wgt_ok_d  = wgt_ok_q;
        in_ready  = 1'b0;
        wr_sel    = 1'b0;
        dp_start  = 1'b0;
        out_valid = 1'b0;
        tmr_load  = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = LOAD_W;
                idx_d   = '0;
            end
            LOAD_W: begin
                in_ready = 1'b1;
                wr_sel   = 1'b1;
                if (in_valid) begin
                    if (idx_q == IDX_W'(NWGT - 1)) begin
                        wgt_ok_d = 1'b1;
                        pend_d   = 1'b0;
                        state_d  = LOAD_D;
                        idx_d    = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_D: begin
                // Reloads only happen on a tile boundary.
                if ((pend_q || !wgt_ok_q) && idx_q == '0) begin
                    state_d = LOAD_W;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (idx_q == IDX_W'(NDAT - 1)) begin
                            state_d  = CALC;
                            idx_d    = '0;
                            tmr_load = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            CALC: begin
                dp_start = tmr_first;
                if (tmr_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (oidx_q == OIDX_W'(NOUT - 1)) begin
                        oidx_d  = '0;
                        tile_d  = tile_q + 1'b1;
                        idx_d   = '0;
                        state_d = pend_q ? LOAD_W : LOAD_D;
                    end else begin
                        oidx_d = oidx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            oidx_q   <= '0;
            tile_q   <= '0;
            pend_q   <= 1'b0;
            wgt_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            oidx_q   <= oidx_d;
            tile_q   <= tile_d;
            pend_q   <= pend_d;
            wgt_ok_q <= wgt_ok_d;
        end
    end

    assign dp_wr_en   = in_valid & in_ready;
    assign dp_wr_sel  = wr_sel;
    assign dp_wr_idx  = in_ready ? idx_q : '0;
    assign dp_wr_data = dp_wr_en ? in_data : '0;
    assign dp_out_idx = oidx_q;
    assign busy       = (state_q != IDLE);
    assign tile_cnt   = tile_q;

endmodule

// File: tb/tb_wc_tile_seq.sv
// Directed scoreboard bench for wc_tile_seq.
module tb_wc_tile_seq;
    import wc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wload;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_data;
    logic        dp_wr_en;
    logic        dp_wr_sel;
    logic [4:0]  dp_wr_idx;
    logic [9:0]  dp_wr_data;
    logic        dp_start;
    logic [1:0]  dp_out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] tile_cnt;

    typedef struct packed {
        logic       sel;
        logic [4:0] idx;
        logic [9:0] data;
    } wr_t;

    wr_t        wq[$];
    logic [1:0] oq[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    wc_tile_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wload  (cfg_wload),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dp_wr_en   (dp_wr_en),
        .dp_wr_sel  (dp_wr_sel),
        .dp_wr_idx  (dp_wr_idx),
        .dp_wr_data (dp_wr_data),
        .dp_start   (dp_start),
        .dp_out_idx (dp_out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .tile_cnt   (tile_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t        ew;
        logic [1:0] eo;
        if (!rst) begin
            if (dp_wr_en) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", {dp_wr_sel, dp_wr_idx, dp_wr_data}, 32'hFFFF_FFFF);
                end else begin
                    ew = wq.pop_front();
                    chk("wr_beat", {dp_wr_sel, dp_wr_idx, dp_wr_data}, ew);
                end
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) begin
                    chk("out_unexpected", dp_out_idx, 32'hFFFF_FFFF);
                end else begin
                    eo = oq.pop_front();
                    chk("out_idx", dp_out_idx, eo);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sel, input logic [4:0] idx,
                        input logic [9:0] data);
        bit ok = 0;
        wq.push_back({sel, idx, data});
        in_valid = 1'b1;
        in_data  = data;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic send_wgts(input logic [9:0] base);
        for (int i = 0; i < NWGT; i++) begin
            send(1'b1, 5'(i), base + 10'(i));
        end
    endtask

    task automatic send_tile(input logic [9:0] base, input int gap,
                             input int cfg_at, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == cfg_at) cfg_wload = 1'b1;
            send(1'b0, 5'(i), base + 10'(i));
            cfg_wload = 1'b0;
            repeat (gap) cyc();
        end
        if (n == NDAT) begin
            for (int k = 0; k < NOUT; k++) oq.push_back(2'(k));
        end
    endtask

    task automatic wait_drain(input int tiles);
        for (int i = 0; i < 200 && oq.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("drain_timeout", oq.size(), 0);
        cyc();
        @(negedge clk);
        chk("drain_ov_low", out_valid, 0);
        chk("drain_tile_cnt", tile_cnt, tiles);
        cyc();
    endtask

    initial begin
        rst       = 1'b1;
        cfg_wload = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_tile_cnt", tile_cnt, 0);
        chk("rst_wr", {dp_wr_en, dp_wr_sel, dp_wr_idx, dp_wr_data}, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        cyc();
        @(negedge clk);
        chk("loadw_in_ready", in_ready, 1);
        chk("loadw_sel", dp_wr_sel, 1);
        chk("loadw_busy", busy, 1);
        cyc();

        // 1: weights, then LOAD_D
        send_wgts(10'h001);
        @(negedge clk);
        chk("loadd_in_ready", in_ready, 1);
        chk("loadd_sel", dp_wr_sel, 0);
        cyc();

        // 2: first tile timing
        send_tile(10'h100, 0, -1, NDAT);
        @(negedge clk);
        chk("t1_start", dp_start, 1);
        chk("t1_ov_c1", out_valid, 0);
        cyc();
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            chk("t1_start_low", dp_start, 0);
            chk("t1_ov_early", out_valid, 0);
            cyc();
        end
        for (int k = 0; k < NOUT; k++) begin
            @(negedge clk);
            chk("t1_ov", out_valid, 1);
            chk("t1_oidx", dp_out_idx, k);
            cyc();
        end
        @(negedge clk);
        chk("t1_ov_done", out_valid, 0);
        chk("t1_tile_cnt", tile_cnt, 1);
        chk("t1_next_ready", in_ready, 1);
        cyc();

        // 3: gapped data beats
        send_tile(10'h200, 1, -1, NDAT);
        wait_drain(2);
        chk("t2_wq_empty", wq.size(), 0);

        // 4: output stall
        out_ready = 1'b0;
        send_tile(10'h300, 0, -1, NDAT);
        cyc();
        cyc();
        cyc();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_ov", out_valid, 1);
            chk("stall_oidx", dp_out_idx, 0);
            chk("stall_in_ready", in_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        wait_drain(3);

        // 5: weight reload requested mid-tile
        send_tile(10'h040, 0, 7, NDAT);
        wait_drain(4);
        send_wgts(10'h011);
        send_tile(10'h180, 0, -1, NDAT);
        wait_drain(5);

        // 6: reset mid-tile
        send_tile(10'h3C0, 0, -1, 10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_start", dp_start, 0);
        chk("mid_rst_oidx", dp_out_idx, 0);
        chk("mid_rst_tile_cnt", tile_cnt, 0);
        chk("mid_rst_wr", {dp_wr_en, dp_wr_sel, dp_wr_idx, dp_wr_data}, 0);
        cyc();
        @(negedge clk);
        chk("mid_rst_loadw", {in_ready, dp_wr_sel, busy}, 3'b111);
        cyc();
        send_wgts(10'h021);
        send_tile(10'h2A0, 0, -1, NDAT);
        wait_drain(1);

        chk("end_wq_empty", wq.size(), 0);
        chk("end_oq_empty", oq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
